// File: rtl/pcs_tx_encoder_pkg.sv
// Shared constants, enums and code helpers for the 64b/66b PCS transmit encoder.
package pcs_params;

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_ERROR = 8'hFE;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] BT_CTRL = 8'h1E;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_S4   = 8'h33;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam logic [63:0] IDLE_BLOCK = {56'd0, BT_CTRL};
    localparam logic [63:0] E_BLOCK    = {{8{CODE_ERROR}}, BT_CTRL};

    typedef enum logic [2:0] {
        CLS_C = 3'd0,
        CLS_S = 3'd1,
        CLS_D = 3'd2,
        CLS_T = 3'd3,
        CLS_E = 3'd4
    } col_class_e;

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_e;

    // Only idle and error are legal control bytes inside a coded column.
    function automatic logic [6:0] code7(input logic [7:0] xg_byte);
        logic [6:0] code;
        if (xg_byte == XG_ERROR) begin
            code = CODE_ERROR;
        end else begin
            code = CODE_IDLE;
        end
        return code;
    endfunction

    function automatic logic [7:0] bt_term(input logic [2:0] lane);
        logic [7:0] bt;
        case (lane)
            3'd0:    bt = 8'h87;
            3'd1:    bt = 8'h99;
            3'd2:    bt = 8'hAA;
            3'd3:    bt = 8'hB4;
            3'd4:    bt = 8'hCC;
            3'd5:    bt = 8'hD2;
            3'd6:    bt = 8'hE1;
            default: bt = 8'hFF;
        endcase
        return bt;
    endfunction

endpackage

// File: rtl/pcs_tx_encoder_if.sv
// XGMII word input and 66-bit block output of the PCS transmit encoder.
interface pcs_tx_encoder_if #(
    parameter int N_CHANNELS = 4,
    parameter int W_BYTE     = 8
);
    logic                         i_clk_en;
    logic [N_CHANNELS-1:0]        i_xgmii_ctrl;
    logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data;
    logic                         o_valid;
    logic [1:0]                   o_hdr;
    logic [63:0]                  o_payload;

    modport master (
        output i_clk_en, i_xgmii_ctrl, i_xgmii_data,
        input  o_valid, o_hdr, o_payload
    );

    modport slave (
        input  i_clk_en, i_xgmii_ctrl, i_xgmii_data,
        output o_valid, o_hdr, o_payload
    );
endinterface

// File: rtl/pcs_tx_block_classify.sv
// Combinational classifier/encoder: one 8-lane XGMII column to class plus {hdr, payload}.
module pcs_tx_block_classify
    import pcs_params::*;
(
    input  logic [7:0]  i_ctrl,
    input  logic [63:0] i_data,
    output col_class_e  o_class,
    output logic [1:0]  o_hdr,
    output logic [63:0] o_payload
);

    logic [7:0]  w_ok;
    logic [7:0]  w_dat;
    logic [7:0]  w_start;
    logic [7:0]  w_term;
    logic [55:0] w_codes;
    logic        w_tmatch;
    logic [2:0]  w_tk;
    logic [63:0] w_tpay;

    // Per-lane decode of the column.
    always_comb begin
        w_ok    = 8'd0;
        w_dat   = 8'd0;
        w_start = 8'd0;
        w_term  = 8'd0;
        w_codes = 56'd0;
        for (int i = 0; i < 8; i++) begin
            w_dat[i]          = ~i_ctrl[i];
            w_ok[i]           = i_ctrl[i] & ((i_data[8*i +: 8] == XG_IDLE) | (i_data[8*i +: 8] == XG_ERROR));
            w_start[i]        = i_ctrl[i] & (i_data[8*i +: 8] == XG_START);
            w_term[i]         = i_ctrl[i] & (i_data[8*i +: 8] == XG_TERM);
            w_codes[7*i +: 7] = code7(i_data[8*i +: 8]);
        end
    end

    // Terminate search: at most one lane can satisfy data-below / idle-above.
    always_comb begin : term_search
        logic v_acc;
        w_tmatch = 1'b0;
        w_tk     = 3'd0;
        v_acc    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v_acc = w_term[k];
            for (int m = 0; m < 8; m++) begin
                v_acc = v_acc & ((m < k) ? w_dat[m] : ((m > k) ? w_ok[m] : 1'b1));
            end
            w_tmatch = w_tmatch | v_acc;
            w_tk     = v_acc ? 3'(k) : w_tk;
        end
    end

    // Terminate payload: data bytes follow the type byte, codes sit at the top, pad is zero.
    always_comb begin
        w_tpay = {56'd0, bt_term(w_tk)};
        for (int m = 0; m < 8; m++) begin
            w_tpay = w_tpay
                   | ((3'(m) < w_tk) ? (64'(i_data[8*m +: 8]) << (8 + 8*m)) : 64'd0)
                   | ((3'(m) > w_tk) ? (64'(w_codes[7*m +: 7]) << (8 + 7*m)) : 64'd0);
        end
    end

    // Column class and encoded block.
    always_comb begin
        o_class   = CLS_E;
        o_hdr     = HDR_CTRL;
        o_payload = E_BLOCK;
        if (&w_ok) begin
            o_class   = CLS_C;
            o_payload = {w_codes, BT_CTRL};
        end else if (&w_dat) begin
            o_class   = CLS_D;
            o_hdr     = HDR_DATA;
            o_payload = i_data;
        end else if (w_start[0] && (&w_dat[7:1])) begin
            o_class   = CLS_S;
            o_payload = {i_data[63:8], BT_S0};
        end else if ((&w_ok[3:0]) && w_start[4] && (&w_dat[7:5])) begin
            o_class   = CLS_S;
            o_payload = {i_data[63:40], 4'd0, w_codes[27:0], BT_S4};
        end else if (w_tmatch) begin
            o_class   = CLS_T;
            o_payload = w_tpay;
        end else begin
            o_class   = CLS_E;
            o_payload = E_BLOCK;
        end
    end

endmodule

// File: rtl/pcs_tx_encoder.sv
// PCS transmit encoder: pairs XGMII words into columns, runs the transmit FSM, registers 66-bit blocks.
module pcs_tx_encoder
    import pcs_params::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int W_BYTE     = 8
)(
    input  logic             i_clk,
    input  logic             i_reset,
    pcs_tx_encoder_if.slave  bus
);

    localparam int W_WORD = N_CHANNELS * W_BYTE;

    localparam logic [2:0] ST_INIT = TX_INIT;
    localparam logic [2:0] ST_C    = TX_C;
    localparam logic [2:0] ST_D    = TX_D;
    localparam logic [2:0] ST_T    = TX_T;
    localparam logic [2:0] ST_E    = TX_E;

    logic                  r_phase;
    logic [N_CHANNELS-1:0] r_lo_ctrl;
    logic [W_WORD-1:0]     r_lo_data;
    logic [2:0]            r_state;
    logic                  r_valid;
    logic [1:0]            r_hdr;
    logic [63:0]           r_payload;

    logic [7:0]            w_col_ctrl;
    logic [63:0]           w_col_data;
    col_class_e            w_class;
    logic [1:0]            w_enc_hdr;
    logic [63:0]           w_enc_payload;
    logic [2:0]            w_next_state;
    logic                  w_legal;

    assign w_col_ctrl = {bus.i_xgmii_ctrl, r_lo_ctrl};
    assign w_col_data = {bus.i_xgmii_data, r_lo_data};

    pcs_tx_block_classify u_classify (
        .i_ctrl    (w_col_ctrl),
        .i_data    (w_col_data),
        .o_class   (w_class),
        .o_hdr     (w_enc_hdr),
        .o_payload (w_enc_payload)
    );

    // Transmit FSM: next state and whether the column may be sent as encoded.
    always_comb begin
        w_next_state = ST_E;
        w_legal      = 1'b0;
        case (r_state)
            ST_INIT, ST_C, ST_T: begin
                case (w_class)
                    CLS_C:   begin w_next_state = ST_C; w_legal = 1'b1; end
                    CLS_S:   begin w_next_state = ST_D; w_legal = 1'b1; end
                    default: begin w_next_state = ST_E; w_legal = 1'b0; end
                endcase
            end
            ST_D: begin
                case (w_class)
                    CLS_D:   begin w_next_state = ST_D; w_legal = 1'b1; end
                    CLS_T:   begin w_next_state = ST_T; w_legal = 1'b1; end
                    default: begin w_next_state = ST_E; w_legal = 1'b0; end
                endcase
            end
            ST_E: begin
                // Every class is accepted here; an E column still encodes as the E block.
                case (w_class)
                    CLS_C:   begin w_next_state = ST_C; w_legal = 1'b1; end
                    CLS_S:   begin w_next_state = ST_D; w_legal = 1'b1; end
                    CLS_D:   begin w_next_state = ST_D; w_legal = 1'b1; end
                    CLS_T:   begin w_next_state = ST_T; w_legal = 1'b1; end
                    default: begin w_next_state = ST_E; w_legal = 1'b0; end
                endcase
            end
            default: begin
                w_next_state = ST_E;
                w_legal      = 1'b0;
            end
        endcase
    end

    // Word pairing, state update and block output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_phase   <= 1'b0;
            r_lo_ctrl <= '0;
            r_lo_data <= '0;
            r_state   <= ST_INIT;
            r_valid   <= 1'b0;
            r_hdr     <= HDR_CTRL;
            r_payload <= IDLE_BLOCK;
        end else if (bus.i_clk_en) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_lo_ctrl <= bus.i_xgmii_ctrl;
                r_lo_data <= bus.i_xgmii_data;
                r_valid   <= 1'b0;
            end else begin
                r_valid   <= 1'b1;
                r_state   <= w_next_state;
                r_hdr     <= w_legal ? w_enc_hdr : HDR_CTRL;
                r_payload <= w_legal ? w_enc_payload : E_BLOCK;
            end
        end
    end

    assign bus.o_valid   = r_valid & bus.i_clk_en;
    assign bus.o_hdr     = r_hdr;
    assign bus.o_payload = r_payload;

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Scoreboard bench for pcs_tx_encoder: a lane-pattern reference model feeds an expected-block queue.
module tb_pcs_tx_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pcs_tx_encoder_if bus ();

    pcs_tx_encoder dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_blk   = 0;

    logic [65:0] exp_q[$];
    int          nxt[5][5];
    logic [7:0]  ttype[8];
    int          mst;
    int          mphase;
    logic [3:0]  lo_c;
    logic [31:0] lo_d;

    function automatic logic [6:0] mcode(input logic [7:0] b);
        return (b == 8'hFE) ? 7'h1E : 7'h00;
    endfunction

    function automatic logic [63:0] e_block();
        logic [63:0] p;
        int pos;
        p = 64'h1E;
        pos = 8;
        for (int i = 0; i < 8; i++) begin
            p = p | (64'(7'h1E) << pos);
            pos += 7;
        end
        return p;
    endfunction

    // Reference: classify the column as a lane-kind string, then pack the block bit-serially.
    function automatic logic [65:0] model_block(input logic [7:0] c, input logic [63:0] d, output int cls);
        string s;
        logic [63:0] p;
        logic [7:0] b;
        int pos;
        int k;
        bit ok;
        s = "";
        for (int i = 0; i < 8; i++) begin
            b = d[8*i +: 8];
            if (!c[i]) s = {s, "D"};
            else if (b == 8'h07 || b == 8'hFE) s = {s, "I"};
            else if (b == 8'hFB) s = {s, "S"};
            else if (b == 8'hFD) s = {s, "T"};
            else s = {s, "X"};
        end
        k = -1;
        for (int i = 0; i < 8; i++) if (s[i] == "T") k = i;
        ok = (k >= 0);
        for (int i = 0; i < 8; i++) begin
            if (i < k && s[i] != "D") ok = 0;
            if (i > k && s[i] != "I") ok = 0;
        end
        p = 64'd0;
        pos = 8;
        cls = 4;
        if (s == "IIIIIIII") begin
            cls = 0;
            p = 64'h1E;
            for (int i = 0; i < 8; i++) begin p = p | (64'(mcode(d[8*i +: 8])) << pos); pos += 7; end
        end else if (s == "DDDDDDDD") begin
            cls = 2;
        end else if (s == "SDDDDDDD") begin
            cls = 1;
            p = 64'h78;
            for (int i = 1; i < 8; i++) begin p = p | (64'(d[8*i +: 8]) << pos); pos += 8; end
        end else if (s == "IIIISDDD") begin
            cls = 1;
            p = 64'h33;
            for (int i = 0; i < 4; i++) begin p = p | (64'(mcode(d[8*i +: 8])) << pos); pos += 7; end
            pos += 4;
            for (int i = 5; i < 8; i++) begin p = p | (64'(d[8*i +: 8]) << pos); pos += 8; end
        end else if (ok) begin
            cls = 3;
            p = 64'(ttype[k]);
            for (int i = 0; i < k; i++) begin p = p | (64'(d[8*i +: 8]) << pos); pos += 8; end
            pos = 64 - 7 * (7 - k);
            for (int i = k + 1; i < 8; i++) begin p = p | (64'(mcode(d[8*i +: 8])) << pos); pos += 7; end
        end else begin
            p = e_block();
        end
        return (cls == 2) ? {2'b01, d} : {2'b10, p};
    endfunction

    task automatic model_col(input logic [7:0] c, input logic [63:0] d);
        logic [65:0] blk;
        int cls;
        int n;
        blk = model_block(c, d, cls);
        n = nxt[mst][cls];
        if (n < 0) begin
            blk = {2'b10, e_block()};
            mst = 4;
        end else begin
            mst = n;
        end
        exp_q.push_back(blk);
    endtask

    task automatic model_word(input logic [3:0] c, input logic [31:0] w);
        if (mphase == 0) begin
            lo_c = c;
            lo_d = w;
            mphase = 1;
        end else begin
            model_col({c, lo_c}, {w, lo_d});
            mphase = 0;
        end
    endtask

    task automatic check66(input string name, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive_word(input logic [3:0] c, input logic [31:0] w, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            bus.i_clk_en     = 1'b0;
            bus.i_xgmii_ctrl = 4'($urandom);
            bus.i_xgmii_data = $urandom;
            @(posedge clk);
            #1;
        end
        bus.i_clk_en     = 1'b1;
        bus.i_xgmii_ctrl = c;
        bus.i_xgmii_data = w;
        model_word(c, w);
        @(posedge clk);
        #1;
    endtask

    task automatic send_col(input logic [7:0] c, input logic [63:0] d, input int gaps);
        drive_word(c[3:0], d[31:0], gaps);
        drive_word(c[7:4], d[63:32], gaps);
    endtask

    task automatic send_idle(input int gaps);
        send_col(8'hFF, 64'h0707070707070707, gaps);
    endtask

    // Expose the pending block with one phase-0 word, then confirm the scoreboard drained.
    task automatic flush_check(input string name);
        if (mphase == 1) drive_word(4'hF, 32'h07070707, 0);
        drive_word(4'hF, 32'h07070707, 0);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic void rand_col(output logic [7:0] c, output logic [63:0] d);
        int kind;
        int k;
        kind = $urandom_range(0, 9);
        d = {$urandom, $urandom};
        c = 8'h00;
        case (kind)
            0, 9: begin
                c = 8'hFF;
                for (int i = 0; i < 8; i++) d[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'h07;
            end
            1: begin c = 8'h01; d[7:0] = 8'hFB; end
            2: begin
                c = 8'h1F;
                for (int i = 0; i < 4; i++) d[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'h07;
                d[39:32] = 8'hFB;
            end
            3, 4, 5: c = 8'h00;
            6: begin
                k = $urandom_range(0, 7);
                c[k] = 1'b1;
                d[8*k +: 8] = 8'hFD;
                for (int i = k + 1; i < 8; i++) begin
                    c[i] = 1'b1;
                    d[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'h07;
                end
            end
            7: begin
                k = $urandom_range(1, 6);
                if (k >= 4) k++;
                c[k] = 1'b1;
                d[8*k +: 8] = 8'hFB;
            end
            default: c = 8'($urandom);
        endcase
    endfunction

    // Monitor: pops one expected block per o_valid and checks gating.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_tests++;
            if (bus.o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_in_reset got=%b exp=0", bus.o_valid);
            end
        end else if (bus.i_clk_en === 1'b0) begin
            n_tests++;
            if (bus.o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_when_disabled got=%b exp=0", bus.o_valid);
            end
        end
        if (bus.o_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block got=%h exp=none", {bus.o_hdr, bus.o_payload});
            end else begin
                logic [65:0] e;
                e = exp_q.pop_front();
                if ({bus.o_hdr, bus.o_payload} !== e) begin
                    n_fail++;
                    $display("FAIL block%0d got=%h exp=%h", n_blk, {bus.o_hdr, bus.o_payload}, e);
                end
            end
            n_blk++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  c;
        logic [63:0] d;
        for (int s = 0; s < 5; s++) for (int k = 0; k < 5; k++) nxt[s][k] = -1;
        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin nxt[s][0] = 1; nxt[s][1] = 2; end
        end
        nxt[2][2] = 2; nxt[2][3] = 3;
        nxt[4][0] = 1; nxt[4][1] = 2; nxt[4][2] = 2; nxt[4][3] = 3; nxt[4][4] = 4;
        ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        mst = 0;
        mphase = 0;

        rst_n = 1'b0;
        bus.i_clk_en = 1'b0;
        bus.i_xgmii_ctrl = 4'hF;
        bus.i_xgmii_data = 32'h07070707;
        repeat (3) @(posedge clk);
        #1;
        check66("reset_block", {bus.o_hdr, bus.o_payload}, {2'b10, 64'h1E});
        check66("reset_valid", 66'(bus.o_valid), 66'd0);
        rst_n = 1'b1;

        repeat (3) send_idle(0);
        send_col(8'h01, {$urandom, $urandom_range(0, 16777215), 8'hFB}, 0);
        send_col(8'h00, {$urandom, $urandom}, 0);
        send_col(8'h00, {$urandom, $urandom}, 0);
        send_col(8'hF8, 64'h07070707_FDCCBBAA, 0);
        send_idle(0);
        send_col(8'h1F, 64'h555555FB_07070707, 0);
        send_col(8'h00, {$urandom, $urandom}, 0);
        send_col(8'hFF, 64'h07070707070707FD, 0);
        send_idle(0);
        d = {$urandom, $urandom};
        d[23:16] = 8'hFB;
        send_col(8'h04, d, 0);
        send_col(8'h00, {$urandom, $urandom}, 0);
        send_col(8'h80, {8'hFD, 24'($urandom), $urandom}, 0);
        send_idle(0);
        flush_check("drain_directed");
        drive_word(4'hF, 32'h07070707, 0);

        send_col(8'h01, {$urandom, $urandom_range(0, 16777215), 8'hFB}, 0);
        send_col(8'h00, {$urandom, $urandom}, 0);
        flush_check("drain_before_reset");
        bus.i_clk_en = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check66("midrun_reset_block", {bus.o_hdr, bus.o_payload}, {2'b10, 64'h1E});
        exp_q.delete();
        mst = 0;
        mphase = 0;
        rst_n = 1'b1;
        send_col(8'h00, {$urandom, $urandom}, 0);
        send_idle(0);

        send_idle(1);
        send_col(8'h01, {$urandom, $urandom_range(0, 16777215), 8'hFB}, 1);
        send_col(8'h00, {$urandom, $urandom}, 1);
        send_col(8'hFF, 64'h07070707070707FD, 1);
        send_idle(1);
        flush_check("drain_throttled");
        drive_word(4'hF, 32'h07070707, 0);

        for (int n = 0; n < 400; n++) begin
            rand_col(c, d);
            send_col(c, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        flush_check("drain_random");

        bus.i_clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
